// File: rtl/exe_mem_stage_pkg.sv
// Shared encodings and field widths for the EX-to-MEM pipeline stage.
package exe_mem_stage_pkg;

  localparam int unsigned MEM_SIZE_W = 2;
  localparam int unsigned WSTRB_W    = 4;
  localparam int unsigned BYTE_OFF_W = 2;

  // Access size as carried by the instruction; the reserved code behaves as a word.
  typedef enum logic [MEM_SIZE_W-1:0] {
    MEM_SIZE_BYTE = 2'd0,
    MEM_SIZE_HALF = 2'd1,
    MEM_SIZE_WORD = 2'd2,
    MEM_SIZE_RSVD = 2'd3
  } mem_size_e;

  localparam logic [WSTRB_W-1:0] WSTRB_NONE    = 4'b0000;
  localparam logic [WSTRB_W-1:0] WSTRB_ALL     = 4'b1111;
  localparam logic [WSTRB_W-1:0] WSTRB_LO_HALF = 4'b0011;
  localparam logic [WSTRB_W-1:0] WSTRB_HI_HALF = 4'b1100;

endpackage

// File: rtl/exe_store_align.sv
// Store data replication, byte-strobe generation and alignment check.
module exe_store_align
  import exe_mem_stage_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [MEM_SIZE_W-1:0] size,
  input  logic [BYTE_OFF_W-1:0] off,
  input  logic [DATA_WIDTH-1:0] rt,
  input  logic                  wr,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [WSTRB_W-1:0]    wstrb,
  output logic                  misalign
);

  // Decode access size into lane-replicated data, strobes and misalignment.
  always_comb begin
    wdata    = rt;
    wstrb    = WSTRB_ALL;
    misalign = 1'b0;
    case (mem_size_e'(size))
      MEM_SIZE_BYTE: begin
        wdata = {(DATA_WIDTH/8){rt[7:0]}};
        wstrb = 4'b0001 << off;
      end
      MEM_SIZE_HALF: begin
        wdata    = {(DATA_WIDTH/16){rt[15:0]}};
        wstrb    = off[1] ? WSTRB_HI_HALF : WSTRB_LO_HALF;
        misalign = off[0];
      end
      default: begin
        wdata    = rt;
        wstrb    = WSTRB_ALL;
        misalign = (off != 2'b00);
      end
    endcase
    if (!wr) wstrb = WSTRB_NONE;
  end

endmodule

// File: rtl/exe_mem_stage.sv
// EX-to-MEM pipeline register with exception qualification and a two-entry skid buffer.
module exe_mem_stage
  import exe_mem_stage_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_alu_result,
  input  logic                  in_overflow,
  input  logic                  in_ov_trap_en,
  input  logic [DATA_WIDTH-1:0] in_rt_data,
  input  logic [REG_ADDR_W-1:0] in_dest,
  input  logic                  in_reg_we,
  input  logic                  in_mem_rd,
  input  logic                  in_mem_wr,
  input  logic [MEM_SIZE_W-1:0] in_mem_size,
  input  logic                  in_mem_sign,
  input  logic [DATA_WIDTH-1:0] in_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic [DATA_WIDTH-1:0] out_wdata,
  output logic [WSTRB_W-1:0]    out_wstrb,
  output logic                  out_mem_rd,
  output logic                  out_mem_wr,
  output logic                  out_reg_we,
  output logic [REG_ADDR_W-1:0] out_dest,
  output logic [MEM_SIZE_W-1:0] out_mem_size,
  output logic                  out_mem_sign,
  output logic [BYTE_OFF_W-1:0] out_byte_off,
  output logic [DATA_WIDTH-1:0] out_pc,
  output logic                  out_exc_ov,
  output logic                  out_exc_adel,
  output logic                  out_exc_ades
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] result;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] pc;
    logic [WSTRB_W-1:0]    wstrb;
    logic                  mem_rd;
    logic                  mem_wr;
    logic                  reg_we;
    logic [REG_ADDR_W-1:0] dest;
    logic [MEM_SIZE_W-1:0] mem_size;
    logic                  mem_sign;
    logic                  exc_ov;
    logic                  exc_adel;
    logic                  exc_ades;
  } entry_t;

  entry_t                main_q, skid_q, dec;
  logic                  main_v, skid_v, rdy_q;
  logic                  main_v_n, skid_v_n;
  logic                  ld_main_skid, ld_main_in, ld_skid;
  logic                  in_fire;
  logic [DATA_WIDTH-1:0] al_wdata;
  logic [WSTRB_W-1:0]    al_wstrb;
  logic                  al_misalign;
  logic                  exc_any;

  exe_store_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .size     (in_mem_size),
    .off      (in_alu_result[BYTE_OFF_W-1:0]),
    .rt       (in_rt_data),
    .wr       (in_mem_wr),
    .wdata    (al_wdata),
    .wstrb    (al_wstrb),
    .misalign (al_misalign)
  );

  // Decode the incoming instruction into the entry format; overflow masks address errors.
  always_comb begin
    dec          = '0;
    dec.result   = in_alu_result;
    dec.wdata    = al_wdata;
    dec.pc       = in_pc;
    dec.dest     = in_dest;
    dec.mem_size = in_mem_size;
    dec.mem_sign = in_mem_sign;
    dec.exc_ov   = in_overflow & in_ov_trap_en;
    dec.exc_adel = al_misalign & in_mem_rd & ~dec.exc_ov;
    dec.exc_ades = al_misalign & in_mem_wr & ~dec.exc_ov;
    exc_any      = dec.exc_ov | dec.exc_adel | dec.exc_ades;
    dec.mem_rd   = in_mem_rd & ~exc_any;
    dec.mem_wr   = in_mem_wr & ~exc_any;
    dec.reg_we   = in_reg_we & ~exc_any;
    dec.wstrb    = exc_any ? WSTRB_NONE : al_wstrb;
  end

  assign in_fire = in_valid & rdy_q;

  // Skid control: main refills from skid first, overflow beats park in skid.
  always_comb begin
    main_v_n     = main_v;
    skid_v_n     = skid_v;
    ld_main_skid = 1'b0;
    ld_main_in   = 1'b0;
    ld_skid      = 1'b0;
    if (flush) begin
      main_v_n = 1'b0;
      skid_v_n = 1'b0;
    end else if (!main_v || out_ready) begin
      if (skid_v) begin
        ld_main_skid = 1'b1;
        main_v_n     = 1'b1;
        skid_v_n     = 1'b0;
      end else if (in_fire) begin
        ld_main_in = 1'b1;
        main_v_n   = 1'b1;
      end else begin
        main_v_n = 1'b0;
      end
    end else if (in_fire) begin
      ld_skid  = 1'b1;
      skid_v_n = 1'b1;
    end
  end

  // Entry registers; in_ready is registered from next skid state so out_ready never reaches it.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      rdy_q  <= 1'b0;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      main_v <= main_v_n;
      skid_v <= skid_v_n;
      rdy_q  <= ~skid_v_n;
      if (ld_main_skid)    main_q <= skid_q;
      else if (ld_main_in) main_q <= dec;
      if (ld_skid)         skid_q <= dec;
    end
  end

  assign in_ready     = rdy_q;
  assign out_valid    = main_v;
  assign out_addr     = main_q.result;
  assign out_result   = main_q.result;
  assign out_wdata    = main_q.wdata;
  assign out_wstrb    = main_q.wstrb;
  assign out_mem_rd   = main_q.mem_rd;
  assign out_mem_wr   = main_q.mem_wr;
  assign out_reg_we   = main_q.reg_we;
  assign out_dest     = main_q.dest;
  assign out_mem_size = main_q.mem_size;
  assign out_mem_sign = main_q.mem_sign;
  assign out_byte_off = main_q.result[BYTE_OFF_W-1:0];
  assign out_pc       = main_q.pc;
  assign out_exc_ov   = main_q.exc_ov;
  assign out_exc_adel = main_q.exc_adel;
  assign out_exc_ades = main_q.exc_ades;

endmodule

// File: tb/tb_exe_mem_stage.sv
// Self-checking bench for exe_mem_stage: directed cases then randomized traffic against a FIFO model.
module tb_exe_mem_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready;
  logic [31:0] in_alu_result, in_rt_data, in_pc;
  logic        in_overflow, in_ov_trap_en, in_reg_we, in_mem_rd, in_mem_wr, in_mem_sign;
  logic [4:0]  in_dest;
  logic [1:0]  in_mem_size;
  logic        out_valid, out_ready;
  logic [31:0] out_addr, out_result, out_wdata, out_pc;
  logic [3:0]  out_wstrb;
  logic        out_mem_rd, out_mem_wr, out_reg_we, out_mem_sign;
  logic [4:0]  out_dest;
  logic [1:0]  out_mem_size, out_byte_off;
  logic        out_exc_ov, out_exc_adel, out_exc_ades;

  always #5 clk = ~clk;

  exe_mem_stage #(.DATA_WIDTH(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_result(in_alu_result), .in_overflow(in_overflow), .in_ov_trap_en(in_ov_trap_en),
    .in_rt_data(in_rt_data), .in_dest(in_dest), .in_reg_we(in_reg_we),
    .in_mem_rd(in_mem_rd), .in_mem_wr(in_mem_wr), .in_mem_size(in_mem_size),
    .in_mem_sign(in_mem_sign), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_result(out_result), .out_wdata(out_wdata), .out_wstrb(out_wstrb),
    .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr), .out_reg_we(out_reg_we),
    .out_dest(out_dest), .out_mem_size(out_mem_size), .out_mem_sign(out_mem_sign),
    .out_byte_off(out_byte_off), .out_pc(out_pc),
    .out_exc_ov(out_exc_ov), .out_exc_adel(out_exc_adel), .out_exc_ades(out_exc_ades)
  );

  typedef struct {
    logic [31:0] addr, wdata, pc;
    logic [3:0]  wstrb;
    logic        rd, wr, we, sign, ov, adel, ades;
    logic [4:0]  dest;
    logic [1:0]  size, off;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   m_ready = 1'b0;
  bit   m_rst = 1'b0;

  // Expected MEM-side view of the instruction currently on the inputs.
  function automatic exp_t predict();
    exp_t        e;
    int unsigned nbytes, off;
    bit          mis, exc;
    off    = in_alu_result % 4;
    nbytes = (in_mem_size == 2'd0) ? 1 : (in_mem_size == 2'd1) ? 2 : 4;
    mis    = (in_alu_result % nbytes) != 0;
    e.ov   = in_overflow && in_ov_trap_en;
    e.adel = mis && in_mem_rd && !e.ov;
    e.ades = mis && in_mem_wr && !e.ov;
    exc    = e.ov || e.adel || e.ades;
    e.rd   = in_mem_rd && !exc;
    e.wr   = in_mem_wr && !exc;
    e.we   = in_reg_we && !exc;
    if (nbytes == 1)      e.wdata = in_rt_data[7:0] * 32'h01010101;
    else if (nbytes == 2) e.wdata = in_rt_data[15:0] * 32'h00010001;
    else                  e.wdata = in_rt_data;
    e.wstrb = e.wr ? 4'(((1 << nbytes) - 1) << off) : 4'b0000;
    e.addr  = in_alu_result;
    e.off   = 2'(off);
    e.pc    = in_pc;
    e.dest  = in_dest;
    e.size  = in_mem_size;
    e.sign  = in_mem_sign;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    exp_t e;
    chk("in_ready", {31'd0, in_ready}, {31'd0, m_ready});
    chk("out_valid", {31'd0, out_valid}, (q.size() > 0) ? 32'd1 : 32'd0);
    if (m_rst) begin
      chk("rst_addr", out_addr, 32'd0);
      chk("rst_result", out_result, 32'd0);
      chk("rst_wdata", out_wdata, 32'd0);
      chk("rst_pc", out_pc, 32'd0);
      chk("rst_ctrl", {12'd0, out_wstrb, out_mem_rd, out_mem_wr, out_reg_we, out_dest,
                       out_mem_size, out_mem_sign, out_byte_off, out_exc_ov, out_exc_adel,
                       out_exc_ades}, 32'd0);
    end else if (q.size() > 0) begin
      e = q[0];
      chk("addr", out_addr, e.addr);
      chk("result", out_result, e.addr);
      chk("wdata", out_wdata, e.wdata);
      chk("wstrb", {28'd0, out_wstrb}, {28'd0, e.wstrb});
      chk("pc", out_pc, e.pc);
      chk("ctrl", {out_mem_rd, out_mem_wr, out_reg_we, out_dest, out_mem_size, out_mem_sign,
                   out_byte_off, out_exc_ov, out_exc_adel, out_exc_ades},
                  {e.rd, e.wr, e.we, e.dest, e.size, e.sign, e.off, e.ov, e.adel, e.ades});
    end
  endtask

  // One clock: update the model at the edge, then check outputs mid-cycle.
  task automatic step();
    bit ofire, ifire;
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_ready = 1'b0;
      m_rst   = 1'b1;
    end else begin
      m_rst = 1'b0;
      if (flush) q.delete();
      else begin
        ofire = (q.size() > 0) && out_ready;
        ifire = in_valid && m_ready;
        if (ofire) void'(q.pop_front());
        if (ifire) q.push_back(predict());
      end
      m_ready = q.size() < 2;
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle();
    flush = 0; in_valid = 0; in_alu_result = '0; in_overflow = 0; in_ov_trap_en = 0;
    in_rt_data = '0; in_dest = '0; in_reg_we = 0; in_mem_rd = 0; in_mem_wr = 0;
    in_mem_size = 2'd2; in_mem_sign = 0; in_pc = '0;
  endtask

  task automatic rand_inputs();
    int unsigned kind;
    kind          = $urandom % 3;
    rst           = ($urandom % 100) == 0;
    flush         = ($urandom % 40) == 0;
    in_valid      = ($urandom % 10) < 7;
    out_ready     = ($urandom % 10) < 6;
    in_alu_result = $urandom;
    in_overflow   = $urandom % 2;
    in_ov_trap_en = $urandom % 2;
    in_rt_data    = $urandom;
    in_dest       = 5'($urandom);
    in_reg_we     = $urandom % 2;
    in_mem_rd     = kind == 1;
    in_mem_wr     = kind == 2;
    in_mem_size   = 2'($urandom);
    in_mem_sign   = $urandom % 2;
    in_pc         = $urandom & 32'hFFFF_FFFC;
  endtask

  initial begin
    // Reset held two cycles with a valid input present.
    idle(); rst = 1; out_ready = 1; in_valid = 1; in_alu_result = 32'h1234; in_pc = 32'h100;
    step(); step();
    rst = 0; in_valid = 0;
    step();
    chk("ready_after_rst", {31'd0, in_ready}, 32'd1);

    // Byte store at offset 3.
    idle(); in_valid = 1; in_alu_result = 32'h0000_1003; in_rt_data = 32'h0000_00AB;
    in_mem_wr = 1; in_mem_size = 2'd0; in_pc = 32'h400;
    step();
    chk("sb_wdata", out_wdata, 32'hABAB_ABAB);
    chk("sb_wstrb", {28'd0, out_wstrb}, 32'h8);
    chk("sb_wr", {31'd0, out_mem_wr}, 32'd1);

    // Misaligned word store.
    idle(); in_valid = 1; in_alu_result = 32'h0000_1002; in_mem_wr = 1; in_mem_size = 2'd2;
    in_pc = 32'h404;
    step();
    chk("sw_ades", {31'd0, out_exc_ades}, 32'd1);
    chk("sw_wr", {31'd0, out_mem_wr}, 32'd0);
    chk("sw_wstrb", {28'd0, out_wstrb}, 32'd0);
    chk("sw_pc", out_pc, 32'h404);

    // Misaligned half load.
    idle(); in_valid = 1; in_alu_result = 32'h0000_1001; in_mem_rd = 1; in_mem_size = 2'd1;
    in_reg_we = 1; in_dest = 5'd3; in_pc = 32'h408;
    step();
    chk("lh_adel", {31'd0, out_exc_adel}, 32'd1);
    chk("lh_rd", {31'd0, out_mem_rd}, 32'd0);
    chk("lh_we", {31'd0, out_reg_we}, 32'd0);

    // Overflow with and without trapping.
    idle(); in_valid = 1; in_overflow = 1; in_ov_trap_en = 1; in_reg_we = 1; in_dest = 5'd7;
    in_pc = 32'h40C;
    step();
    chk("ov_exc", {31'd0, out_exc_ov}, 32'd1);
    chk("ov_we", {31'd0, out_reg_we}, 32'd0);
    in_ov_trap_en = 0; in_pc = 32'h410;
    step();
    chk("nov_exc", {31'd0, out_exc_ov}, 32'd0);
    chk("nov_we", {31'd0, out_reg_we}, 32'd1);
    idle();
    step();

    // Backpressure: A held, B parks in skid, C stalls until drain.
    out_ready = 0; in_valid = 1; in_reg_we = 1; in_alu_result = 32'hA0; in_pc = 32'h500;
    step();
    chk("bp_a", out_pc, 32'h500);
    in_alu_result = 32'hB0; in_pc = 32'h504;
    step();
    chk("bp_a_hold1", out_pc, 32'h500);
    chk("bp_full", {31'd0, in_ready}, 32'd0);
    in_alu_result = 32'hC0; in_pc = 32'h508;
    step();
    chk("bp_a_hold2", out_pc, 32'h500);
    out_ready = 1;
    step();
    chk("bp_b", out_pc, 32'h504);
    step();
    chk("bp_c", out_pc, 32'h508);
    in_valid = 0;
    step();
    chk("bp_empty", {31'd0, out_valid}, 32'd0);

    // Flush with both entries full and an input presented.
    out_ready = 0; in_valid = 1; in_pc = 32'h600;
    step();
    in_pc = 32'h604;
    step();
    flush = 1; in_pc = 32'h608;
    step();
    chk("fl_valid", {31'd0, out_valid}, 32'd0);
    chk("fl_ready", {31'd0, in_ready}, 32'd1);
    flush = 0; in_valid = 0; out_ready = 1;
    step();

    // Flush with room available: the presented input must still be dropped.
    out_ready = 0; in_valid = 1; in_pc = 32'h610;
    step();
    flush = 1; in_pc = 32'h614;
    step();
    flush = 0; in_valid = 0; out_ready = 1;
    step();
    chk("fl2_dropped", {31'd0, out_valid}, 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exe_mem_stage.md
Name: exe_mem_stage

Overview:
- EX-to-MEM pipeline stage of the CPU. It registers the ALU result with the instruction's control fields, checks memory alignment and arithmetic overflow, and builds store write-data and byte strobes.
- Between EX and MEM it uses a valid/ready handshake with a two-entry skid buffer, so MEM backpressure never drops an instruction.

Parameters:
- DATA_WIDTH, 32, datapath width (ALU result, store data, PC).
- REG_ADDR_W, 5, destination register index width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- flush  input  1  discard all held and incoming entries.
- in_valid  input  1  EX presents an instruction.
- in_ready  output  1  stage can accept this cycle.
- in_alu_result  input  DATA_WIDTH  ALU Result (memory address for loads/stores).
- in_overflow  input  1  ALU Overflow flag.
- in_ov_trap_en  input  1  instruction traps on overflow (add/addi/sub).
- in_rt_data  input  DATA_WIDTH  store source data.
- in_dest  input  REG_ADDR_W  writeback register.
- in_reg_we  input  1  writeback enable.
- in_mem_rd / in_mem_wr  input  1 each  load / store.
- in_mem_size  input  2  0 byte, 1 half, 2 word, 3 treated as word.
- in_mem_sign  input  1  sign-extend load.
- in_pc  input  DATA_WIDTH  instruction PC.
- out_valid  output  1  entry presented to MEM.
- out_ready  input  1  MEM accepts.
- out_addr, out_result  output  DATA_WIDTH  both equal the registered ALU result.
- out_wdata  output  DATA_WIDTH  replicated store data.
- out_wstrb  output  4  byte strobes.
- out_mem_rd, out_mem_wr, out_reg_we  output  1 each  post-exception qualified controls.
- out_dest  output  REG_ADDR_W.
- out_mem_size  output  2.
- out_mem_sign  output  1.
- out_byte_off  output  2  address bits [1:0].
- out_pc  output  DATA_WIDTH.
- out_exc_ov, out_exc_adel, out_exc_ades  output  1 each  overflow, load address error, store address error.

Behaviour:
- Reset:
  - Both entries invalid. All outputs 0; in_ready 0 during rst.
  - in_ready is 1 the first cycle after rst deasserts.
- Decode is combinational on the input side; the entry stores already-decoded fields. Latency: in fire at cycle N gives out_valid at N+1.
- Store alignment:
  - byte: wdata = {4{rt[7:0]}}, wstrb = 4'b0001 << off.
  - half: wdata = {2{rt[15:0]}}, wstrb = off[1] ? 1100 : 0011.
  - word: wdata = rt, wstrb = 1111.
  - wstrb is 0 when mem_wr = 0.
- Exceptions, priority ov > address error:
  - exc_ov = in_overflow & in_ov_trap_en.
  - A misalign is half with off[0]=1, or word with off!=0.
  - exc_adel = misalign & mem_rd & ~exc_ov; exc_ades = misalign & mem_wr & ~exc_ov.
  - Any exception forces mem_rd, mem_wr, reg_we and wstrb to 0. pc, dest and result are kept for EPC/BadVAddr.
- Handshake: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
  - Main entry drives the outputs. Skid entry holds one overflow beat.
  - Main empty or out_fire: main loads skid if skid valid (skid cleared), else loads input if in_fire, else goes invalid.
  - in_fire while main is held and no out_fire: input goes into skid.
  - in_ready = ~skid_valid, registered with no combinational path from out_ready.
  - Outputs stay stable while out_valid & ~out_ready.
  - Order preserved; no beat lost or duplicated.
- Flush:
  - Next cycle both entries are invalid and in_ready = 1.
  - An input presented in the flush cycle is dropped even if in_valid = 1.
  - Flush has priority over out_fire. An out_fire in the same cycle still completes from MEM's view.
- rst during any transfer: same as flush, plus all outputs zeroed.

Decomposition:
- Shared package:
  - MEM_SIZE_BYTE/HALF/WORD encodings.
  - Strobe constants WSTRB_NONE/ALL/LO_HALF/HI_HALF.
  - Entry field widths.
- One combinational sub-module, exe_store_align: takes size, off, rt and wr; produces wdata, wstrb and misalign. The skid and handshake control stay in the top module.

Test Plan:
- Reset: hold rst 2 cycles with in_valid=1 -> out_valid=0, all outputs 0, in_ready=0. Release -> in_ready=1 next cycle.
- sb: addr 0x00001003, rt 0x000000AB, out_ready=1 -> next cycle out_wdata 0xABABABAB, out_wstrb 1000, out_mem_wr=1.
- Misaligned sw: addr 0x00001002 -> out_exc_ades=1, out_mem_wr=0, out_wstrb=0, out_pc equals input pc.
- Misaligned lh: addr 0x00001001 -> out_exc_adel=1, out_mem_rd=0, out_reg_we=0.
- Overflow: trap_en=1, overflow=1, reg_we=1 -> out_exc_ov=1, out_reg_we=0. Same with trap_en=0 -> exc_ov=0, reg_we=1.
- Backpressure: out_ready=0, push A, B, C on consecutive cycles -> A held stable, B in skid, in_ready=0 after B, C stalls at input. Raise out_ready -> A, B, C emerge in order, one per cycle.
- Flush: both entries full, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, dropped input never appears.
